// File: rtl/ir_fetch_queue.sv
// ir_fetch_queue: DEPTH-entry prefetch FIFO feeding a decoded instruction
// register. The fetch side pushes with valid/ready, the control FSM pops the
// head into the IR with ir_load, and flush drops everything on a redirect.
// Decoded fields are plain slices of the IR flops (no extra latency).
module ir_fetch_queue #(
    parameter int INSTR_W  = 16,
    parameter int OP_W     = 4,
    parameter int REG_W    = 3,
    parameter int DATA_W   = 16,
    parameter int DEPTH    = 4,
    localparam int FUNCT_W = INSTR_W - OP_W - 3 * REG_W,
    localparam int IMM_I_W = REG_W + FUNCT_W,
    localparam int IMM_J_W = INSTR_W - OP_W,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               fetch_valid,
    input  logic [INSTR_W-1:0] fetch_data,
    output logic               fetch_ready,
    input  logic               ir_load,
    input  logic               flush,
    output logic               ir_valid,
    output logic [CNT_W-1:0]   q_count,
    output logic [OP_W-1:0]    op,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rt,
    output logic [REG_W-1:0]   rd,
    output logic [FUNCT_W-1:0] funct,
    output logic [DATA_W-1:0]  imm_i,
    output logic [IMM_J_W-1:0] imm_j
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    // Queue storage; the IR itself acts as the registered read port.
    logic [INSTR_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]   wptr_reg, wptr_next;
    logic [PTR_W-1:0]   rptr_reg, rptr_next;
    logic [CNT_W-1:0]   count_reg, count_next;
    logic               ir_valid_reg, ir_valid_next;
    logic [INSTR_W-1:0] ir_reg;
    logic               push;
    logic               pop;

    // Ready depends only on the registered count, never on same-cycle ir_load,
    // so a full queue refuses a push even while it is being popped.
    assign fetch_ready = (count_reg != FULL_CNT);
    assign push        = fetch_valid && fetch_ready && !flush;
    assign pop         = ir_load && (count_reg != '0) && !flush;

    // Next-state for pointers, occupancy and IR valid; flush overrides all.
    always_comb begin
        wptr_next     = wptr_reg;
        rptr_next     = rptr_reg;
        count_next    = count_reg;
        ir_valid_next = ir_valid_reg;
        if (flush) begin
            wptr_next     = '0;
            rptr_next     = '0;
            count_next    = '0;
            ir_valid_next = 1'b0;
        end else begin
            if (push) begin
                wptr_next = wptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rptr_next     = rptr_reg + PTR_W'(1);
                ir_valid_next = 1'b1;
            end else if (ir_load) begin
                // Load requested from an empty queue: insert a bubble.
                ir_valid_next = 1'b0;
            end
            count_next = count_reg + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state registers with asynchronous clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wptr_reg     <= '0;
            rptr_reg     <= '0;
            count_reg    <= '0;
            ir_valid_reg <= 1'b0;
        end else begin
            wptr_reg     <= wptr_next;
            rptr_reg     <= rptr_next;
            count_reg    <= count_next;
            ir_valid_reg <= ir_valid_next;
        end
    end

    // Queue write port; contents need no reset since occupancy gates reads.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr_reg] <= fetch_data;
        end
    end

    // IR captures the queue head on a successful pop and otherwise holds.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ir_reg <= '0;
        end else if (pop) begin
            ir_reg <= mem[rptr_reg];
        end
    end

    assign ir_valid = ir_valid_reg;
    assign q_count  = count_reg;

    // Field slices straight from the IR flops.
    assign op    = ir_reg[INSTR_W-1 -: OP_W];
    assign rs    = ir_reg[INSTR_W-OP_W-1 -: REG_W];
    assign rt    = ir_reg[INSTR_W-OP_W-REG_W-1 -: REG_W];
    assign rd    = ir_reg[INSTR_W-OP_W-2*REG_W-1 -: REG_W];
    assign funct = ir_reg[FUNCT_W-1:0];
    assign imm_j = ir_reg[IMM_J_W-1:0];

    // I-type immediate: low IMM_I_W bits copied, upper bits replicate the sign.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_imm_i
            if (gi < IMM_I_W) begin : g_low
                assign imm_i[gi] = ir_reg[gi];
            end else begin : g_sign
                assign imm_i[gi] = ir_reg[IMM_I_W-1];
            end
        end
    endgenerate

endmodule

// File: tb/tb_ir_fetch_queue.sv
// Directed bench for ir_fetch_queue: stimulus pushes expected IR contents into
// a scoreboard queue whenever it issues ir_load; a monitor pops and compares
// after each accepted load edge. Occupancy/ready checks are made inline.
module tb_ir_fetch_queue;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_valid;
    logic [15:0] fetch_data;
    logic        fetch_ready;
    logic        ir_load;
    logic        flush;
    logic        ir_valid;
    logic [2:0]  q_count;
    logic [3:0]  op;
    logic [2:0]  rs;
    logic [2:0]  rt;
    logic [2:0]  rd;
    logic [2:0]  funct;
    logic [15:0] imm_i;
    logic [11:0] imm_j;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct packed {
        logic        v;
        logic [15:0] w;
    } exp_t;

    exp_t exp_q[$];

    always #5 clock = ~clock;

    ir_fetch_queue #(
        .INSTR_W(16), .OP_W(4), .REG_W(3), .DATA_W(16), .DEPTH(4)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_ready (fetch_ready),
        .ir_load     (ir_load),
        .flush       (flush),
        .ir_valid    (ir_valid),
        .q_count     (q_count),
        .op          (op),
        .rs          (rs),
        .rt          (rt),
        .rd          (rd),
        .funct       (funct),
        .imm_i       (imm_i),
        .imm_j       (imm_j)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s = %0h", name, act);
        end
    endtask

    // Apply one cycle of inputs starting at a falling edge; return at the next.
    task automatic step(input logic fv, input logic [15:0] fd, input logic ld, input logic fl);
        fetch_valid = fv;
        fetch_data  = fd;
        ir_load     = ld;
        flush       = fl;
        @(negedge clock);
        fetch_valid = 1'b0;
        ir_load     = 1'b0;
        flush       = 1'b0;
    endtask

    // Issue ir_load (optionally with a push) and record the expected IR.
    task automatic load_exp(input logic v, input logic [15:0] w,
                            input logic fv, input logic [15:0] fd);
        exp_t e;
        e.v = v;
        e.w = w;
        exp_q.push_back(e);
        step(fv, fd, 1'b1, 1'b0);
    endtask

    // Monitor: after every edge that carried an unflushed ir_load, compare IR.
    always @(posedge clock) begin
        if (reset_n && ir_load && !flush) begin
            @(negedge clock);
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_load: got load with empty scoreboard (t=%0t)", $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_ir_valid", 32'(ir_valid), 32'(e.v));
                chk("mon_ir_word", 32'({op, rs, rt, rd, funct}), 32'(e.w));
                chk("mon_imm_i", 32'(imm_i), 32'({{10{e.w[5]}}, e.w[5:0]}));
                chk("mon_imm_j", 32'(imm_j), 32'(e.w[11:0]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] w;
        reset_n     = 1'b0;
        fetch_valid = 1'b0;
        fetch_data  = 16'h0;
        ir_load     = 1'b0;
        flush       = 1'b0;

        // Reset held while inputs toggle.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            fetch_valid = 1'b1;
            fetch_data  = 16'hFFFF;
            ir_load     = 1'b1;
            flush       = (i == 1);
        end
        @(negedge clock);
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_q_count", 32'(q_count), 32'd0);
        chk("rst_ir_valid", 32'(ir_valid), 32'd0);
        chk("rst_op", 32'(op), 32'd0);
        chk("rst_imm_i", 32'(imm_i), 32'd0);
        chk("rst_imm_j", 32'(imm_j), 32'd0);
        fetch_valid = 1'b0;
        ir_load     = 1'b0;
        flush       = 1'b0;
        reset_n     = 1'b1;

        // Basic push then load with field decode.
        step(1'b1, 16'h1234, 1'b0, 1'b0);
        chk("push1_q_count", 32'(q_count), 32'd1);
        load_exp(1'b1, 16'h1234, 1'b0, 16'h0);
        chk("dec_op", 32'(op), 32'd1);
        chk("dec_rs", 32'(rs), 32'd1);
        chk("dec_rt", 32'(rt), 32'd0);
        chk("dec_rd", 32'(rd), 32'd6);
        chk("dec_funct", 32'(funct), 32'd4);
        chk("dec_imm_j", 32'(imm_j), 32'h234);
        chk("dec_ir_valid", 32'(ir_valid), 32'd1);
        chk("dec_q_count", 32'(q_count), 32'd0);

        // No bypass: push and load on an empty queue gives a bubble.
        load_exp(1'b0, 16'h1234, 1'b1, 16'h50BF);
        chk("bypass_q_count", 32'(q_count), 32'd1);
        chk("bypass_ir_valid", 32'(ir_valid), 32'd0);
        load_exp(1'b1, 16'h50BF, 1'b0, 16'h0);
        chk("sext_neg_imm_i", 32'(imm_i), 32'hFFFF);
        step(1'b1, 16'h501F, 1'b0, 1'b0);
        load_exp(1'b1, 16'h501F, 1'b0, 16'h0);
        chk("sext_pos_imm_i", 32'(imm_i), 32'h001F);

        // Fill to full, fifth push refused, drain in order, then empty load.
        for (int i = 1; i <= 4; i++) begin
            w = 16'hA000 + 16'(i);
            step(1'b1, w, 1'b0, 1'b0);
        end
        chk("full_fetch_ready", 32'(fetch_ready), 32'd0);
        chk("full_q_count", 32'(q_count), 32'd4);
        step(1'b1, 16'hA005, 1'b0, 1'b0);
        chk("full_refuse_q_count", 32'(q_count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            w = 16'hA000 + 16'(i);
            load_exp(1'b1, w, 1'b0, 16'h0);
        end
        chk("drain_q_count", 32'(q_count), 32'd0);
        load_exp(1'b0, 16'hA004, 1'b0, 16'h0);
        chk("empty_ir_valid", 32'(ir_valid), 32'd0);
        chk("empty_imm_j", 32'(imm_j), 32'h004);

        // Simultaneous push and pop at two entries and at full.
        step(1'b1, 16'hB001, 1'b0, 1'b0);
        step(1'b1, 16'hB002, 1'b0, 1'b0);
        chk("sim2_pre_q_count", 32'(q_count), 32'd2);
        load_exp(1'b1, 16'hB001, 1'b1, 16'hB003);
        chk("sim2_q_count", 32'(q_count), 32'd2);
        step(1'b1, 16'hB004, 1'b0, 1'b0);
        step(1'b1, 16'hB005, 1'b0, 1'b0);
        chk("sim4_pre_q_count", 32'(q_count), 32'd4);
        load_exp(1'b1, 16'hB002, 1'b1, 16'hB006);
        chk("sim4_q_count", 32'(q_count), 32'd3);

        // Twenty push+pop cycles at three entries: pointers wrap several times.
        for (int i = 0; i < 20; i++) begin
            w = (i < 3) ? (16'hB003 + 16'(i)) : (16'hC000 + 16'(i - 3));
            load_exp(1'b1, w, 1'b1, 16'hC000 + 16'(i));
            chk("wrap_q_count", 32'(q_count), 32'd3);
        end
        for (int i = 17; i < 20; i++) begin
            w = 16'hC000 + 16'(i);
            load_exp(1'b1, w, 1'b0, 16'h0);
        end
        chk("wrap_drain_q_count", 32'(q_count), 32'd0);

        // Flush with push and load in the same cycle.
        for (int i = 1; i <= 4; i++) begin
            w = 16'hD000 + 16'(i);
            step(1'b1, w, 1'b0, 1'b0);
        end
        load_exp(1'b1, 16'hD001, 1'b0, 16'h0);
        chk("preflush_q_count", 32'(q_count), 32'd3);
        step(1'b1, 16'hDEAD, 1'b1, 1'b1);
        chk("flush_q_count", 32'(q_count), 32'd0);
        chk("flush_ir_valid", 32'(ir_valid), 32'd0);
        chk("flush_fetch_ready", 32'(fetch_ready), 32'd1);
        step(1'b1, 16'hE001, 1'b0, 1'b0);
        load_exp(1'b1, 16'hE001, 1'b0, 16'h0);
        chk("postflush_q_count", 32'(q_count), 32'd0);

        // Asynchronous reset pulse mid-stream clears state without a clock edge.
        step(1'b1, 16'hF001, 1'b0, 1'b0);
        step(1'b1, 16'hF002, 1'b0, 1'b0);
        load_exp(1'b1, 16'hF001, 1'b0, 16'h0);
        chk("prerst_q_count", 32'(q_count), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_q_count", 32'(q_count), 32'd0);
        chk("arst_ir_valid", 32'(ir_valid), 32'd0);
        chk("arst_op", 32'(op), 32'd0);
        chk("arst_imm_j", 32'(imm_j), 32'd0);
        chk("arst_fetch_ready", 32'(fetch_ready), 32'd1);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b1, 16'hF003, 1'b0, 1'b0);
        chk("postrst_q_count", 32'(q_count), 32'd1);
        load_exp(1'b1, 16'hF003, 1'b0, 16'h0);
        chk("postrst_ir_valid", 32'(ir_valid), 32'd1);

        repeat (2) @(negedge clock);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ir_fetch_queue.md
Name: ir_fetch_queue

Overview:
- Parametrised successor to the single-stage instruction register: a DEPTH-entry prefetch FIFO in front of a decoded instruction register.
- Fetch side pushes words with a valid/ready handshake; control FSM pulls the head into the IR with ir_load (IRWrite role).
- Decoded fields and immediates (sign-extended I-type) come straight from IR flops.
- Flush discards queued and held instructions on branch/jump redirect.

Parameters:
- INSTR_W, 16, instruction word width
- OP_W, 4, opcode width (top bits)
- REG_W, 3, register-specifier width (rs, rt, rd)
- DATA_W, 16, datapath width for sign-extended I immediate (>= IMM_I_W)
- DEPTH, 4, FIFO entries; power of 2, >= 2
- Derived: FUNCT_W = INSTR_W-OP_W-3*REG_W (must be >= 1); IMM_I_W = REG_W+FUNCT_W; IMM_J_W = INSTR_W-OP_W; CNT_W = clog2(DEPTH+1)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- fetch_valid  in  1  fetch_data holds a word
- fetch_data  in  INSTR_W  fetched instruction
- fetch_ready  out  1  queue can accept a word this cycle
- ir_load  in  1  pop FIFO head into IR
- flush  in  1  discard queue and IR contents
- ir_valid  out  1  IR holds a live instruction
- q_count  out  CNT_W  queued entries, excluding IR
- op  out  OP_W  IR[INSTR_W-1 -: OP_W]
- rs  out  REG_W  next REG_W bits below op
- rt  out  REG_W  next REG_W bits below rs
- rd  out  REG_W  next REG_W bits below rt
- funct  out  FUNCT_W  IR[FUNCT_W-1:0]
- imm_i  out  DATA_W  IR[IMM_I_W-1:0], sign-extended to DATA_W
- imm_j  out  IMM_J_W  IR[IMM_J_W-1:0], raw

Behaviour:
- Reset (reset_n low, async): FIFO pointers and q_count = 0, IR = 0, ir_valid = 0.
- During reset, all fields = 0 and fetch_ready = 1.
- fetch_ready = (q_count != DEPTH). It is combinational from registered count only and never depends on ir_load in the same cycle.
- Push: fetch_valid && fetch_ready at a rising edge writes fetch_data at the write pointer; wptr += 1 mod DEPTH.
- Pop/load: ir_load && q_count != 0 at an edge:
  - IR <= head, ir_valid <= 1, rptr += 1 mod DEPTH.
  - Fields update on that same edge.
- ir_load with empty queue: IR contents hold, ir_valid <= 0 (bubble).
- No ir_load: IR and ir_valid hold.
- Latency: a word pushed at edge k is loadable no earlier than edge k+1. There is no fetch-to-IR bypass.
- Simultaneous push and pop: both occur and q_count is unchanged. When full, a push is refused even if a pop happens the same cycle.
- q_count next value = q_count + push - pop. It never exceeds DEPTH and never underflows.
- Pointer wrap: binary pointers of width clog2(DEPTH) wrap naturally. Full and empty are distinguished by q_count.
- flush (highest priority):
  - At the edge, q_count <= 0, wptr = rptr <= 0, ir_valid <= 0.
  - Same-cycle push and ir_load are ignored. IR field values hold; they are don't-care while ir_valid = 0.
- Reset asserted mid-operation clears state immediately regardless of clock. The first push after release is accepted on the first edge with reset_n high.
- Field extraction is purely combinational from IR flops, with no extra latency.

Test Plan:
- Reset: hold reset_n = 0, toggle inputs -> fetch_ready = 1, q_count = 0, ir_valid = 0, op/imm_i/imm_j = 0. Release, push 16'h1234, ir_load next cycle -> op = 1, rs = 1, rt = 0, rd = 6, funct = 4, imm_j = 12'h234, ir_valid = 1.
- Sign extension: load 16'h50BF -> imm_i = 16'hFFFF (IMM_I 6'h3F). Load 16'h501F -> imm_i = 16'h001F.
- Full/backpressure: push 5 words (DEPTH = 4) with ir_load = 0 -> fetch_ready low after 4th, q_count = 4, 5th not accepted. Pop all -> order preserved, 5th absent.
- Simultaneous push+pop at q_count = 2 -> q_count stays 2. At q_count = 4 -> push refused, q_count = 3. Run 20 such cycles -> pointer wrap with no loss or reorder.
- Empty load: ir_load with q_count = 0 -> ir_valid drops to 0, fields unchanged.
- Flush with push and ir_load asserted same cycle, q_count = 3 -> q_count = 0, ir_valid = 0, pushed word dropped. Next pushed word is the next loaded. Async reset pulse mid-stream -> immediate clear.
